// File: rtl/clock_div_monitor.sv
// Frequency/health monitor for a divided clock, sampled in the clk_in domain.
// Measures each clk_mon half-period, locks after consecutive good intervals, latches faults.
module clock_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_HALF   = 2,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 16,
    parameter int ERR_W      = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             clk_mon,
    input  logic             clear_fault,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [CNT_W:0]   EXP_V     = (CNT_W+1)'(EXP_HALF);
    localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       LOCK_V    = 4'(LOCK_COUNT);

    // Absolute deviation check, widened by one bit so cnt+1 never wraps.
    function automatic logic in_tol(input logic [CNT_W:0] meas);
        logic [CNT_W:0] dev;
        dev = (meas >= EXP_V) ? (meas - EXP_V) : (EXP_V - meas);
        return (dev <= TOL_V);
    endfunction

    logic             s1_r, s2_r, s3_r;
    logic             edge_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [3:0]       good_r, good_next_s;
    state_t           state_r, state_next_s;
    logic [CNT_W:0]   meas_s;
    logic [CNT_W-1:0] half_sat_s;
    logic             good_meas_s, timeout_s, fault_entry_s;
    logic             edge_pulse_r, locked_r, fault_r;
    logic [CNT_W-1:0] half_period_r;
    logic [ERR_W-1:0] err_count_r;

    assign edge_s = s2_r ^ s3_r;

    // Interval measurement and timeout detection from the running counter.
    always_comb begin
        meas_s        = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        half_sat_s    = meas_s[CNT_W] ? CNT_MAX : meas_s[CNT_W-1:0];
        good_meas_s   = in_tol(meas_s);
        timeout_s     = (cnt_r == TIMEOUT_V) && !edge_s;
    end

    // Next-state, good-count and counter logic; disable and fault-clear take priority.
    always_comb begin
        state_next_s = state_r;
        good_next_s  = good_r;
        if (!en || ((state_r == ST_FAULT) && clear_fault)) begin
            state_next_s = ST_IDLE;
            good_next_s  = 4'd0;
        end else if (edge_s || timeout_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        state_next_s = ST_ACQUIRE;
                        good_next_s  = 4'd0;
                    end else begin
                        state_next_s = ST_FAULT;
                    end
                end
                ST_ACQUIRE: begin
                    if (!edge_s) begin
                        state_next_s = ST_FAULT;
                    end else if (good_meas_s) begin
                        good_next_s = good_r + 4'd1;
                        if ((good_r + 4'd1) == LOCK_V) begin
                            state_next_s = ST_LOCKED;
                        end else begin
                            state_next_s = ST_ACQUIRE;
                        end
                    end else begin
                        good_next_s = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (edge_s && good_meas_s) begin
                        state_next_s = ST_LOCKED;
                    end else begin
                        state_next_s = ST_FAULT;
                    end
                end
                ST_FAULT: state_next_s = ST_FAULT;
                default:  state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end

        if (!en || ((state_r == ST_FAULT) && clear_fault) || edge_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end

        fault_entry_s = (state_next_s == ST_FAULT) && (state_r != ST_FAULT);
    end

    // Synchroniser, measurement registers, FSM state and status outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1_r          <= 1'b0;
            s2_r          <= 1'b0;
            s3_r          <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            good_r        <= 4'd0;
            state_r       <= ST_IDLE;
            edge_pulse_r  <= 1'b0;
            half_period_r <= {CNT_W{1'b0}};
            locked_r      <= 1'b0;
            fault_r       <= 1'b0;
            err_count_r   <= {ERR_W{1'b0}};
        end else begin
            s1_r         <= clk_mon;
            s2_r         <= s1_r;
            s3_r         <= s2_r;
            cnt_r        <= cnt_next_s;
            good_r       <= good_next_s;
            state_r      <= state_next_s;
            edge_pulse_r <= edge_s;
            locked_r     <= (state_next_s == ST_LOCKED);
            fault_r      <= (state_next_s == ST_FAULT);
            if (edge_s) begin
                half_period_r <= half_sat_s;
            end else begin
                half_period_r <= half_period_r;
            end
            if (fault_entry_s && (err_count_r != ERR_MAX)) begin
                err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign edge_pulse  = edge_pulse_r;
    assign half_period = half_period_r;
    assign locked      = locked_r;
    assign fault       = fault_r;
    assign err_count   = err_count_r;
    assign state       = state_r;

endmodule

// File: tb/tb_clock_div_monitor.sv
// Scenario bench for clock_div_monitor: a queue of clk_mon intervals drives the monitored
// clock, and each expected half_period is queued at the toggle and popped on edge_pulse.
module tb_clock_div_monitor;

    logic       clk_in = 1'b0;
    logic       reset, en, clk_mon, clear_fault;
    logic       edge_pulse, locked, fault;
    logic [7:0] half_period, err_count;
    logic [1:0] state;
    logic       edge_pulse_t1, locked_t1, fault_t1;
    logic [7:0] half_period_t1, err_count_t1;
    logic [1:0] state_t1;

    int vectors = 0;
    int miscompares = 0;
    int sbq[$];
    int ivq[$];
    int hold = 0;
    int cycles = 0;
    int last_tog = -1;
    int pulses = 0;
    int t_last;

    clock_div_monitor dut (
        .clk_in(clk_in), .reset(reset), .en(en), .clk_mon(clk_mon), .clear_fault(clear_fault),
        .edge_pulse(edge_pulse), .half_period(half_period), .locked(locked), .fault(fault),
        .err_count(err_count), .state(state)
    );

    clock_div_monitor #(.TOL(1)) dut_t1 (
        .clk_in(clk_in), .reset(reset), .en(en), .clk_mon(clk_mon), .clear_fault(clear_fault),
        .edge_pulse(edge_pulse_t1), .half_period(half_period_t1), .locked(locked_t1),
        .fault(fault_t1), .err_count(err_count_t1), .state(state_t1)
    );

    always #5 clk_in = ~clk_in;

    // One clk_in cycle: score any edge_pulse, then advance the clk_mon interval stimulus.
    task automatic tick();
        int exp_hp;
        @(posedge clk_in);
        #1;
        cycles++;
        if (edge_pulse) begin
            pulses++;
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected_edge: edge_pulse=1 at cycle %0d, required 0", cycles);
            end else begin
                exp_hp = sbq.pop_front();
                if (exp_hp >= 0) begin
                    vectors++;
                    if (half_period !== exp_hp[7:0]) begin
                        miscompares++;
                        $display("FAIL sb_half_period: got %0d, required %0d (cycle %0d)",
                                 half_period, exp_hp, cycles);
                    end
                end
            end
        end
        if (hold > 0) hold--;
        if (hold == 0 && ivq.size() > 0) begin
            clk_mon = ~clk_mon;
            if (last_tog < 0) sbq.push_back(-1);
            else sbq.push_back((cycles - last_tog > 255) ? 255 : cycles - last_tog);
            last_tog = cycles;
            hold = ivq.pop_front();
        end
    endtask

    task automatic run_pulses(input int target);
        for (int i = 0; i < 300 && pulses < target; i++) tick();
    endtask

    task automatic run_drain();
        for (int i = 0; i < 300 && (ivq.size() > 0 || hold > 0); i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk_mon = 1'b0;
        clear_fault = 1'b0;
        sbq.delete();
        ivq.delete();
        hold = 0;
        last_tog = -1;
        pulses = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1;
        clk_mon = 1'b0;
        clear_fault = 1'b0;
        tick();
        tick();
        vectors++; if (edge_pulse !== 1'b0) begin miscompares++; $display("FAIL rst_edge_pulse: got %0d, required 0", edge_pulse); end
        vectors++; if (half_period !== 8'd0) begin miscompares++; $display("FAIL rst_half_period: got %0d, required 0", half_period); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_locked: got %0d, required 0", locked); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault: got %0d, required 0", fault); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL rst_err_count: got %0d, required 0", err_count); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d, required 0", state); end
        do_reset();
    endtask

    task automatic test_lock();
        for (int i = 0; i < 10; i++) ivq.push_back(2);
        run_pulses(4);
        vectors++; if (pulses !== 4) begin miscompares++; $display("FAIL lock_pulse4_seen: got %0d pulses, required 4", pulses); end
        vectors++; if (state !== 2'd1 || locked !== 1'b0) begin miscompares++; $display("FAIL lock_pre: state=%0d locked=%0d, required 1/0", state, locked); end
        run_pulses(5);
        vectors++; if (locked !== 1'b1 || state !== 2'd2) begin miscompares++; $display("FAIL lock_5th: locked=%0d state=%0d, required 1/2", locked, state); end
        vectors++; if (fault !== 1'b0 || err_count !== 8'd0) begin miscompares++; $display("FAIL lock_status: fault=%0d err=%0d, required 0/0", fault, err_count); end
    endtask

    task automatic test_stuck();
        run_drain();
        t_last = last_tog;
        for (int i = 0; i < 300 && cycles < t_last + 18; i++) tick();
        vectors++; if (fault !== 1'b0 || state !== 2'd2) begin miscompares++; $display("FAIL stuck_early: fault=%0d state=%0d, required 0/2", fault, state); end
        tick();
        vectors++; if (fault !== 1'b1 || locked !== 1'b0 || state !== 2'd3) begin miscompares++; $display("FAIL stuck_fault: fault=%0d locked=%0d state=%0d, required 1/0/3", fault, locked, state); end
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL stuck_err: got %0d, required 1", err_count); end
        repeat (40) tick();
        vectors++; if (err_count !== 8'd1 || state !== 2'd3) begin miscompares++; $display("FAIL stuck_hold: err=%0d state=%0d, required 1/3", err_count, state); end
    endtask

    task automatic test_stretch();
        pulse_clear();
        vectors++; if (state !== 2'd0 || fault !== 1'b0) begin miscompares++; $display("FAIL stretch_clear: state=%0d fault=%0d, required 0/0", state, fault); end
        last_tog = -1;
        pulses = 0;
        ivq = '{2, 2, 2, 2, 2, 2, 3, 2, 2};
        run_pulses(7);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL stretch_locked: got %0d, required 1", locked); end
        run_pulses(8);
        vectors++; if (half_period !== 8'd3) begin miscompares++; $display("FAIL stretch_half: got %0d, required 3", half_period); end
        vectors++; if (fault !== 1'b1 || state !== 2'd3 || err_count !== 8'd2) begin miscompares++; $display("FAIL stretch_fault: fault=%0d state=%0d err=%0d, required 1/3/2", fault, state, err_count); end
        run_drain();
        repeat (30) tick();
        vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL stretch_err_hold: got %0d, required 2", err_count); end
    endtask

    task automatic test_tolerance();
        do_reset();
        ivq = '{2, 2, 1, 2, 2, 2, 2, 3, 2};
        run_pulses(4);
        vectors++; if (state !== 2'd1 || state_t1 !== 2'd1) begin miscompares++; $display("FAIL tol_p4: state=%0d state_t1=%0d, required 1/1", state, state_t1); end
        run_pulses(5);
        vectors++; if (locked_t1 !== 1'b1 || locked !== 1'b0) begin miscompares++; $display("FAIL tol_p5: locked_t1=%0d locked=%0d, required 1/0", locked_t1, locked); end
        run_pulses(7);
        vectors++; if (locked !== 1'b0 || state !== 2'd1) begin miscompares++; $display("FAIL tol_p7: locked=%0d state=%0d, required 0/1", locked, state); end
        run_pulses(8);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL tol_p8_relock: got %0d, required 1", locked); end
        run_pulses(9);
        vectors++; if (fault !== 1'b1 || err_count !== 8'd1) begin miscompares++; $display("FAIL tol_p9_fault: fault=%0d err=%0d, required 1/1", fault, err_count); end
        vectors++; if (locked_t1 !== 1'b1 || fault_t1 !== 1'b0 || err_count_t1 !== 8'd0) begin miscompares++; $display("FAIL tol_p9_t1: locked=%0d fault=%0d err=%0d, required 1/0/0", locked_t1, fault_t1, err_count_t1); end
    endtask

    task automatic test_clear_edge();
        run_drain();
        for (int i = 0; i < 14; i++) ivq.push_back(2);
        pulses = 0;
        tick();
        tick();
        tick();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        vectors++; if (edge_pulse !== 1'b1 || state !== 2'd0 || fault !== 1'b0) begin miscompares++; $display("FAIL clr_edge: edge=%0d state=%0d fault=%0d, required 1/0/0", edge_pulse, state, fault); end
        run_pulses(5);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL clr_p5: locked=%0d, required 0", locked); end
        run_pulses(6);
        vectors++; if (locked !== 1'b1 || state !== 2'd2) begin miscompares++; $display("FAIL clr_relock: locked=%0d state=%0d, required 1/2", locked, state); end
    endtask

    task automatic test_enable();
        en = 1'b0;
        tick();
        vectors++; if (state !== 2'd0 || locked !== 1'b0) begin miscompares++; $display("FAIL en_idle: state=%0d locked=%0d, required 0/0", state, locked); end
        en = 1'b1;
        foreach (sbq[i]) sbq[i] = -1;
        last_tog = -1;
        pulses = 0;
        for (int i = 0; i < 10; i++) ivq.push_back(2);
        run_pulses(4);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL en_p4: locked=%0d, required 0", locked); end
        run_pulses(5);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL en_relock: locked=%0d, required 1", locked); end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (locked !== 1'b0 || state !== 2'd0 || fault !== 1'b0) begin miscompares++; $display("FAIL arst_state: locked=%0d state=%0d fault=%0d, required 0/0/0", locked, state, fault); end
        vectors++; if (half_period !== 8'd0 || err_count !== 8'd0 || edge_pulse !== 1'b0) begin miscompares++; $display("FAIL arst_regs: half=%0d err=%0d edge=%0d, required 0/0/0", half_period, err_count, edge_pulse); end
        do_reset();
    endtask

    task automatic test_err_saturation();
        int exp_err;
        for (int i = 0; i < 260; i++) begin
            for (int k = 0; k < 40 && fault !== 1'b1; k++) tick();
            vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL sat_timeout: no fault in iteration %0d", i); end
            exp_err = (i + 1 > 255) ? 255 : i + 1;
            if (i == 0 || i == 99 || i == 254 || i == 259) begin
                vectors++; if (err_count !== exp_err[7:0]) begin miscompares++; $display("FAIL sat_err_count: got %0d, required %0d", err_count, exp_err); end
            end
            pulse_clear();
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stuck();
        test_stretch();
        test_tolerance();
        test_clear_edge();
        test_enable();
        test_async_reset();
        test_err_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_div_monitor.md
Name: clock_div_monitor

Overview:
- Checks a divided clock (e.g. the divide-by-4 output of the clock divider) from the fast source-clock domain.
- Synchronises the monitored clock, detects its edges, and measures each half-period in source-clock cycles.
- Declares lock after consecutive in-tolerance measurements; raises a sticky fault on an out-of-tolerance interval or a stuck clock.
- Sits beside the divider and feeds status logic.

Parameters:
CNT_W, 8, width of the half-period counter and the half_period output
EXP_HALF, 2, expected half-period in clk_in cycles (2 for divide-by-4)
TOL, 0, allowed absolute deviation from EXP_HALF, in cycles
LOCK_COUNT, 4, consecutive good measurements required to lock (1..15)
TIMEOUT, 16, clk_in cycles without an edge before a stuck fault (must be less than 2^CNT_W-1)
ERR_W, 8, width of err_count

Ports:
clk_in  input  1  source clock; all logic on its rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
en  input  1  monitor enable; 0 holds the FSM in IDLE
clk_mon  input  1  monitored divided clock, treated as asynchronous
clear_fault  input  1  single-cycle pulse: leave FAULT, return to IDLE
edge_pulse  output  1  one-cycle pulse per detected clk_mon edge (rise or fall)
half_period  output  CNT_W  last measured edge-to-edge interval in clk_in cycles
locked  output  1  high only in state LOCKED
fault  output  1  high only in state FAULT
err_count  output  ERR_W  saturating count of fault events
state  output  2  IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3

Behaviour:
- Reset (async, active-high): all outputs 0, synchroniser flops 0, cnt=0, good=0, state=IDLE.
- Synchroniser: three flops s1->s2->s3 sample clk_mon on every cycle, independent of en. edge = s2 XOR s3.
- Edge latency: edge_pulse (registered) is high on the 3rd clk_in rising edge, counting as the 1st the edge that first samples the new clk_mon level.
- cnt on the cycle edge is registered:
  - half_period <= min(cnt+1, 2^CNT_W-1)
  - cnt <= 0
- cnt on other cycles: cnt <= cnt+1, saturating at 2^CNT_W-1.
- Good measurement: |(cnt+1) - EXP_HALF| <= TOL, computed at CNT_W+1 bits.
- Timeout: cnt == TIMEOUT-1 with no edge in that cycle. Fires once, because FAULT absorbs it; cnt keeps saturating.
- FSM (evaluated on edge cycles and timeout cycles):
  - IDLE: the first edge enters ACQUIRE with good=0; this interval is not judged, but half_period is still updated. Timeout -> FAULT.
  - ACQUIRE: good measurement -> good+1; when good reaches LOCK_COUNT -> LOCKED. Bad measurement -> good=0, stay in ACQUIRE. Timeout -> FAULT.
  - LOCKED: good measurement -> stay. Bad measurement or timeout -> FAULT.
  - FAULT: sticky. Edges still update half_period and edge_pulse. clear_fault -> IDLE with good=0, cnt=0.
- err_count increments by 1 on each entry into FAULT and saturates at 2^ERR_W-1. It is never cleared except by reset.
- en=0: next state is IDLE, cnt=0, good=0. half_period, err_count and edge_pulse keep working.
- Simultaneous events:
  - clear_fault with an edge: clear wins, state=IDLE, edge not judged.
  - Bad measurement with LOCK_COUNT reached: bad wins.
  - en=0 with clear_fault: IDLE.
- locked and fault are decoded from the registered state, so they change in the same cycle as state.
- Reset mid-operation returns to the reset values asynchronously, with no clock edge needed.

Test Plan:
- Divide-by-4 stimulus from the clock divider on the same clk_in, defaults -> half_period=2 on every edge_pulse, locked=1 on the 5th edge_pulse (1 unjudged + 4 good), fault=0, err_count=0.
- While LOCKED, hold clk_mon low -> 16 cycles after the last edge: fault=1, locked=0, state=3, err_count=1, with no further increment while stuck.
- While LOCKED, stretch one half-period to 3 cycles (TOL=0) -> half_period=3, FAULT on that edge_pulse cycle, err_count increments.
- In ACQUIRE, give 2 good intervals, then a 1-cycle interval -> good resets, and locked needs 4 further good intervals. Repeat with TOL=1 -> the 1-cycle and 3-cycle intervals count as good.
- In FAULT, pulse clear_fault on the same cycle as an edge -> state=0, then relock after 5 edges. Pulse en=0 -> state=0 immediately.
- Assert reset asynchronously mid-LOCKED, between clock edges -> all outputs 0 before the next clk_in edge. Drive err_count past 2^ERR_W-1 faults -> saturates at 255.
